cline_req_iterator: RTL and testbench
=====================================

// Module: cline_req_iterator
// PURPOSE
//  Next-generation cache-line span unit for the reference-fetch path, shared by luma and chroma via parameters.
//  Accepts one reference block (start x/y, width-1, height-1) and computes its cache-line span per axis.
//  Sequentially issues one (line_x, line_y) tag request per touched cache line, with valid/ready on both sides.
//  Sits between the MV-to-block address stage and the tag-compare stage of the ref cache.
// PARAMETERS
//  C_L_H_SIZE   3   log2 cache-line width in pixels
//  C_L_V_SIZE   2   log2 cache-line height in rows
//  DIM_WDTH     4   bits of rf_blk_wdt_in (block width-1)
//  DIM_HGHT     4   bits of rf_blk_hgt_in (block height-1)
//  X_WDTH       12  pixel x coordinate width; line_x = X_WDTH-C_L_H_SIZE bits
//  Y_WDTH       12  pixel y coordinate width; line_y = Y_WDTH-C_L_V_SIZE bits
//  localparam DX_WDTH = DIM_WDTH-C_L_H_SIZE+1, DY_WDTH = DIM_HGHT-C_L_V_SIZE+1 (delta widths)
// PORTS
//  clk            in   1        clock
//  reset          in   1        asynchronous, active-high reset
//  blk_valid_in   in   1        block descriptor valid
//  blk_ready_out  out  1        iterator idle, descriptor accepted when valid&ready
//  start_x_in     in   X_WDTH   block top-left x (pixels)
//  start_y_in     in   Y_WDTH   block top-left y (rows)
//  rf_blk_wdt_in  in   DIM_WDTH block width minus one
//  rf_blk_hgt_in  in   DIM_HGHT block height minus one
//  abort_in       in   1        drop current block (sync)
//  req_valid_out  out  1        line request valid
//  req_ready_in   in   1        downstream accepts request
//  req_x_out      out  X_WDTH-C_L_H_SIZE  cache-line x index
//  req_y_out      out  Y_WDTH-C_L_V_SIZE  cache-line y index
//  req_last_out   out  1        final request of current block
//  delta_x_out    out  DX_WDTH  lines spanned in x minus one, registered at accept
//  delta_y_out    out  DY_WDTH  lines spanned in y minus one, registered at accept
//  perf_lines_out out  32       present only with CLINE_ITER_PERF_EN
// BEHAVIOUR
//  Reset values: blk_ready_out=1, req_valid_out=0, req_last_out=0, req_x/y_out=0, delta_x/y_out=0, perf=0.
//  Span: end_x=(start_x+wdt) mod 2^X_WDTH; delta_x=(end_x>>C_L_H_SIZE)-(start_x>>C_L_H_SIZE) mod 2^DX_WDTH.
//   y is identical with C_L_V_SIZE/DY_WDTH. Line indices wrap modulo their width (frame-edge wrap is legal).
//  FSM IDLE: blk_ready_out=1; on blk_valid_in -> latch start lines, deltas, zero counters, go ISSUE.
//  FSM ISSUE: blk_ready_out=0; req_valid_out=1 from the cycle after accept (latency 1).
//   Order x-inner, y-outer. Request = (start_line_x+cx, start_line_y+cy), cx in 0..delta_x, cy in 0..delta_y.
//   On req_valid&req_ready: cx++; at cx==delta_x -> cx=0, cy++. req_last_out = (cx==delta_x)&&(cy==delta_y).
//   Handshake on last -> IDLE; blk_ready_out=1 next cycle (one bubble; no same-cycle re-accept).
//   req_ready_in low: all req_* outputs held stable; valid never drops without handshake except abort/reset.
//  abort_in (any state): next cycle IDLE, req_valid_out=0; abort wins over a simultaneous handshake or accept.
//  Reset mid-block: immediate return to IDLE, pending requests discarded.
//  Total requests per block = (delta_x+1)*(delta_y+1); 1 when block lies within a single line.
// CONFIGURATION
//  CLINE_ITER_PERF_EN defined: perf_lines_out counts completed request handshakes, wraps at 2^32, clears on reset only.
//  Not defined: port, counter and logic absent; all other behaviour identical.
// STRUCTURE
//  Shared cache config header: C_L_H_SIZE/C_L_V_SIZE per component, FSM state encodings (IDLE=0, ISSUE=1).
//  Sub-module cline_span_calc: combinational end/delta/start-line computation, one instance per axis.
//  Top: accept regs, cx/cy counters, 2-state FSM, output regs, optional perf counter.
// TESTING (defaults)
//  start(0,0) wdt=7 hgt=3 -> one request (0,0), last=1, delta_x=0, delta_y=0.
//  start(6,3) wdt=3 hgt=1 -> (0,0),(1,0),(0,1),(1,1); last only on 4th; deltas 1,1.
//  Test 2 with req_ready_in low 3 cycles after first valid -> req_x/y/last stable, no skipped or repeated lines.
//  start_x=4092 wdt=7, y in-line -> requests x=511 then x=0; delta_x=1.
//  reset after 2nd handshake of a 4-line block -> next cycle req_valid=0, blk_ready=1; abort_in repeats result.
//  CLINE_ITER_PERF_EN defined, run test 1 then test 2 -> perf_lines_out=5.

Source files
------------

// File: rtl/cline_req_iterator_pkg.sv
// Shared cache-line configuration for the reference-fetch path.
// Holds the per-component cache-line geometry and the iterator FSM encoding.
package cline_req_iterator_pkg;

    // log2 cache-line geometry per colour component
    localparam int LUMA_C_L_H_SIZE   = 3;
    localparam int LUMA_C_L_V_SIZE   = 2;
    localparam int CHROMA_C_L_H_SIZE = 2;
    localparam int CHROMA_C_L_V_SIZE = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } iter_state_e;

endpackage

// File: rtl/cline_span_calc.sv
// Per-axis cache-line span: start line index and (lines touched - 1).
// Purely combinational; coordinates and line indices wrap at their widths.
module cline_span_calc #(
    parameter int COORD_W = 12,
    parameter int DIM_W   = 4,
    parameter int LINE_SZ = 3,
    parameter int DELTA_W = 2
) (
    input  logic [COORD_W-1:0]         start_i,
    input  logic [DIM_W-1:0]           dim_i,
    output logic [COORD_W-LINE_SZ-1:0] start_line_o,
    output logic [DELTA_W-1:0]         delta_o
);
    localparam int LINE_W = COORD_W - LINE_SZ;

    logic [COORD_W-1:0] end_pix;
    logic [LINE_W-1:0]  end_line;

    // end pixel wraps at the frame edge, so the line difference is taken modulo too
    always_comb begin
        end_pix      = start_i + COORD_W'(dim_i);
        start_line_o = start_i[COORD_W-1:LINE_SZ];
        end_line     = end_pix[COORD_W-1:LINE_SZ];
        delta_o      = DELTA_W'(end_line - start_line_o);
    end

endmodule

// File: rtl/cline_req_iterator.sv
// Cache-line request iterator: accepts one reference block and issues one
// (line_x, line_y) tag request per touched cache line, x-inner / y-outer.
// Optional feature: define CLINE_ITER_PERF_EN to add perf_lines_out, a
// free-running count of completed request handshakes.
module cline_req_iterator
    import cline_req_iterator_pkg::*;
#(
    parameter int C_L_H_SIZE = LUMA_C_L_H_SIZE,
    parameter int C_L_V_SIZE = LUMA_C_L_V_SIZE,
    parameter int DIM_WDTH   = 4,
    parameter int DIM_HGHT   = 4,
    parameter int X_WDTH     = 12,
    parameter int Y_WDTH     = 12,
    localparam int DX_WDTH   = DIM_WDTH - C_L_H_SIZE + 1,
    localparam int DY_WDTH   = DIM_HGHT - C_L_V_SIZE + 1,
    localparam int LX_W      = X_WDTH - C_L_H_SIZE,
    localparam int LY_W      = Y_WDTH - C_L_V_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                blk_valid_in,
    output logic                blk_ready_out,
    input  logic [X_WDTH-1:0]   start_x_in,
    input  logic [Y_WDTH-1:0]   start_y_in,
    input  logic [DIM_WDTH-1:0] rf_blk_wdt_in,
    input  logic [DIM_HGHT-1:0] rf_blk_hgt_in,
    input  logic                abort_in,
    output logic                req_valid_out,
    input  logic                req_ready_in,
    output logic [LX_W-1:0]     req_x_out,
    output logic [LY_W-1:0]     req_y_out,
    output logic                req_last_out,
    output logic [DX_WDTH-1:0]  delta_x_out,
    output logic [DY_WDTH-1:0]  delta_y_out
`ifdef CLINE_ITER_PERF_EN
    ,
    output logic [31:0]         perf_lines_out
`endif
);

    iter_state_e         state_q, state_d;
    logic [LX_W-1:0]     sx_line, sx_q, sx_d;
    logic [LY_W-1:0]     sy_line, sy_q, sy_d;
    logic [DX_WDTH-1:0]  dx_calc, dx_q, dx_d, cx_q, cx_d, cx_nxt;
    logic [DY_WDTH-1:0]  dy_calc, dy_q, dy_d, cy_q, cy_d, cy_nxt;
    logic                req_valid_q, req_valid_d, req_last_q, req_last_d;
    logic [LX_W-1:0]     req_x_q, req_x_d;
    logic [LY_W-1:0]     req_y_q, req_y_d;
    logic                accept, hs, row_end;

    cline_span_calc #(
        .COORD_W(X_WDTH), .DIM_W(DIM_WDTH), .LINE_SZ(C_L_H_SIZE), .DELTA_W(DX_WDTH)
    ) u_span_x (
        .start_i(start_x_in), .dim_i(rf_blk_wdt_in), .start_line_o(sx_line), .delta_o(dx_calc)
    );

    cline_span_calc #(
        .COORD_W(Y_WDTH), .DIM_W(DIM_HGHT), .LINE_SZ(C_L_V_SIZE), .DELTA_W(DY_WDTH)
    ) u_span_y (
        .start_i(start_y_in), .dim_i(rf_blk_hgt_in), .start_line_o(sy_line), .delta_o(dy_calc)
    );

    // abort blocks a same-cycle accept and overrides a same-cycle handshake
    assign accept  = blk_valid_in && (state_q == ST_IDLE) && !abort_in;
    assign hs      = req_valid_q && req_ready_in;
    assign row_end = (cx_q == dx_q);
    assign cx_nxt  = row_end ? '0 : cx_q + 1'b1;
    assign cy_nxt  = row_end ? cy_q + 1'b1 : cy_q;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: accept starts a block, last handshake or abort ends it
    always_comb begin
        state_d = state_q;
        if (abort_in) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (accept)            state_d = ST_ISSUE;
                ST_ISSUE: if (hs && req_last_q)  state_d = ST_IDLE;
                default:                         state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: only idle accepts a new descriptor
    always_comb begin
        blk_ready_out = (state_q == ST_IDLE);
    end

    // Datapath next state: latch span on accept, advance counters on handshake;
    // outputs hold whenever no handshake occurs
    always_comb begin
        sx_d        = sx_q;
        sy_d        = sy_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        req_valid_d = req_valid_q;
        req_last_d  = req_last_q;
        req_x_d     = req_x_q;
        req_y_d     = req_y_q;
        if (abort_in) begin
            req_valid_d = 1'b0;
            req_last_d  = 1'b0;
        end else if (accept) begin
            sx_d        = sx_line;
            sy_d        = sy_line;
            dx_d        = dx_calc;
            dy_d        = dy_calc;
            cx_d        = '0;
            cy_d        = '0;
            req_valid_d = 1'b1;
            req_x_d     = sx_line;
            req_y_d     = sy_line;
            req_last_d  = (dx_calc == '0) && (dy_calc == '0);
        end else if (hs) begin
            if (req_last_q) begin
                req_valid_d = 1'b0;
                req_last_d  = 1'b0;
            end else begin
                cx_d       = cx_nxt;
                cy_d       = cy_nxt;
                req_x_d    = sx_q + LX_W'(cx_nxt);
                req_y_d    = sy_q + LY_W'(cy_nxt);
                req_last_d = (cx_nxt == dx_q) && (cy_nxt == dy_q);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx_q        <= '0;
            sy_q        <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            req_valid_q <= 1'b0;
            req_last_q  <= 1'b0;
            req_x_q     <= '0;
            req_y_q     <= '0;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            req_valid_q <= req_valid_d;
            req_last_q  <= req_last_d;
            req_x_q     <= req_x_d;
            req_y_q     <= req_y_d;
        end
    end

    assign req_valid_out = req_valid_q;
    assign req_last_out  = req_last_q;
    assign req_x_out     = req_x_q;
    assign req_y_out     = req_y_q;
    assign delta_x_out   = dx_q;
    assign delta_y_out   = dy_q;

`ifdef CLINE_ITER_PERF_EN
    logic [31:0] perf_q;

    // Completed request handshakes; an aborted handshake does not count
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                perf_q <= '0;
        else if (hs && !abort_in) perf_q <= perf_q + 32'd1;
    end

    assign perf_lines_out = perf_q;
`endif

endmodule

// File: tb/tb_cline_req_iterator.sv
// Scoreboard bench for cline_req_iterator: stimulus pushes hand-computed
// requests, a negedge monitor pops and compares on every handshake and
// checks that stalled outputs stay put.
module tb_cline_req_iterator;
    localparam int X_WDTH = 12, Y_WDTH = 12, DIM_WDTH = 4, DIM_HGHT = 4;
    localparam int LX = 9, LY = 10, DX = 2, DY = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              blk_valid_in = 1'b0;
    logic              blk_ready_out;
    logic [X_WDTH-1:0] start_x_in = '0;
    logic [Y_WDTH-1:0] start_y_in = '0;
    logic [DIM_WDTH-1:0] rf_blk_wdt_in = '0;
    logic [DIM_HGHT-1:0] rf_blk_hgt_in = '0;
    logic              abort_in = 1'b0;
    logic              req_valid_out;
    logic              req_ready_in = 1'b1;
    logic [LX-1:0]     req_x_out;
    logic [LY-1:0]     req_y_out;
    logic              req_last_out;
    logic [DX-1:0]     delta_x_out;
    logic [DY-1:0]     delta_y_out;
`ifdef CLINE_ITER_PERF_EN
    logic [31:0]       perf_lines_out;
`endif

    cline_req_iterator dut (
        .clk(clk), .reset(reset),
        .blk_valid_in(blk_valid_in), .blk_ready_out(blk_ready_out),
        .start_x_in(start_x_in), .start_y_in(start_y_in),
        .rf_blk_wdt_in(rf_blk_wdt_in), .rf_blk_hgt_in(rf_blk_hgt_in),
        .abort_in(abort_in),
        .req_valid_out(req_valid_out), .req_ready_in(req_ready_in),
        .req_x_out(req_x_out), .req_y_out(req_y_out), .req_last_out(req_last_out),
        .delta_x_out(delta_x_out), .delta_y_out(delta_y_out)
`ifdef CLINE_ITER_PERF_EN
        , .perf_lines_out(perf_lines_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int last; } exp_t;
    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int x, input int y, input int last);
        exp_t e;
        e.x = x; e.y = y; e.last = last;
        sb.push_back(e);
    endtask

    // Monitor: compare each handshake against the scoreboard; stalled outputs must hold
    bit prev_stall = 0;
    int prev_x, prev_y, prev_last;
    always @(negedge clk) begin
        exp_t e;
        if (reset || abort_in) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", req_valid_out, 1);
                chk("stall_x", req_x_out, prev_x);
                chk("stall_y", req_y_out, prev_y);
                chk("stall_last", req_last_out, prev_last);
            end
            if (req_valid_out && req_ready_in) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req actual=(%0d,%0d) expected=none", req_x_out, req_y_out);
                end else begin
                    e = sb.pop_front();
                    chk("req_x", req_x_out, e.x);
                    chk("req_y", req_y_out, e.y);
                    chk("req_last", req_last_out, e.last);
                end
            end
            prev_stall = req_valid_out && !req_ready_in;
            prev_x = req_x_out;
            prev_y = req_y_out;
            prev_last = req_last_out;
        end
    end

    // Issue one descriptor; caller is at posedge+1. Checks accept latency and deltas.
    task automatic send(input int sx, input int sy, input int w, input int h,
                        input int edx, input int edy);
        int n = 0;
        while (!blk_ready_out && n < 50) begin @(posedge clk); #1; n++; end
        chk("blk_ready_idle", blk_ready_out, 1);
        start_x_in = X_WDTH'(sx); start_y_in = Y_WDTH'(sy);
        rf_blk_wdt_in = DIM_WDTH'(w); rf_blk_hgt_in = DIM_HGHT'(h);
        blk_valid_in = 1'b1;
        @(posedge clk); #1;
        blk_valid_in = 1'b0;
        chk("blk_ready_busy", blk_ready_out, 0);
        chk("req_valid_lat1", req_valid_out, 1);
        chk("delta_x", delta_x_out, edx);
        chk("delta_y", delta_y_out, edy);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || !blk_ready_out) && n < 100) begin @(posedge clk); #1; n++; end
        chk("block_done_in_time", int'(n < 100), 1);
        chk("sb_empty", sb.size(), 0);
        chk("valid_low_after", req_valid_out, 0);
    endtask

    task automatic wait_two_left();
        int n = 0;
        while (sb.size() != 2 && n < 50) begin @(posedge clk); #1; n++; end
        chk("two_handshakes_in_time", int'(n < 50), 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_blk_ready", blk_ready_out, 1);
        chk("rst_req_valid", req_valid_out, 0);
        chk("rst_req_last", req_last_out, 0);
        chk("rst_req_x", req_x_out, 0);
        chk("rst_req_y", req_y_out, 0);
        chk("rst_delta_x", delta_x_out, 0);
        chk("rst_delta_y", delta_y_out, 0);
`ifdef CLINE_ITER_PERF_EN
        chk("rst_perf", perf_lines_out, 0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        // single line block
        push_exp(0, 0, 1);
        send(0, 0, 7, 3, 0, 0);
        wait_done();

        // 2x2 lines
        push_exp(0, 0, 0); push_exp(1, 0, 0); push_exp(0, 1, 0); push_exp(1, 1, 1);
        send(6, 3, 3, 1, 1, 1);
        wait_done();
`ifdef CLINE_ITER_PERF_EN
        chk("perf_after_t1_t2", perf_lines_out, 5);
`endif

        // 2x2 lines with downstream stalled 3 cycles after first valid
        req_ready_in = 1'b0;
        push_exp(0, 0, 0); push_exp(1, 0, 0); push_exp(0, 1, 0); push_exp(1, 1, 1);
        send(6, 3, 3, 1, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("stalled_x", req_x_out, 0);
        chk("stalled_y", req_y_out, 0);
        req_ready_in = 1'b1;
        wait_done();

        // x wraps at the frame edge
        push_exp(511, 2, 0); push_exp(0, 2, 1);
        send(4092, 8, 7, 2, 1, 0);
        wait_done();

        // 3 lines wide, y wraps at the frame edge
        push_exp(0, 1023, 0); push_exp(1, 1023, 0); push_exp(2, 1023, 0);
        push_exp(0, 0, 0);    push_exp(1, 0, 0);    push_exp(2, 0, 1);
        send(7, 4093, 15, 3, 2, 1);
        wait_done();

        // reset after second handshake of a 4-line block
        push_exp(0, 0, 0); push_exp(1, 0, 0); push_exp(0, 1, 0); push_exp(1, 1, 1);
        send(6, 3, 3, 1, 1, 1);
        wait_two_left();
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", req_valid_out, 0);
        chk("rstmid_ready", blk_ready_out, 1);
        chk("rstmid_last", req_last_out, 0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // abort after second handshake of a 4-line block
        push_exp(0, 0, 0); push_exp(1, 0, 0); push_exp(0, 1, 0); push_exp(1, 1, 1);
        send(6, 3, 3, 1, 1, 1);
        wait_two_left();
        abort_in = 1'b1;
        @(posedge clk); #1;
        abort_in = 1'b0;
        chk("abort_valid", req_valid_out, 0);
        chk("abort_ready", blk_ready_out, 1);
        chk("abort_last", req_last_out, 0);
        sb.delete();

        // abort wins over a simultaneous accept
        start_x_in = '0; start_y_in = '0; rf_blk_wdt_in = '0; rf_blk_hgt_in = '0;
        blk_valid_in = 1'b1;
        abort_in = 1'b1;
        @(posedge clk); #1;
        blk_valid_in = 1'b0;
        abort_in = 1'b0;
        chk("abort_accept_ready", blk_ready_out, 1);
        chk("abort_accept_valid", req_valid_out, 0);

        // normal operation resumes
        push_exp(0, 0, 1);
        send(0, 0, 7, 3, 0, 0);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
